// File: rtl/pkg_keccak.sv
// Shared Keccak constants and types for the input-side block buffer.
package pkg_keccak;

  localparam int IN_BUF_SIZE = 64;
  localparam int RATE_WORDS  = 17;
  localparam int CNT_W       = $clog2(RATE_WORDS);

  localparam logic [7:0] PAD_FIRST = 8'h01;
  localparam logic [7:0] PAD_LAST  = 8'h80;

  typedef enum logic [1:0] {FILL, PAD, FULL} buf_in_state_t;

endpackage

// File: rtl/keccak_pad_word.sv
// Byte-granular pad10*1 for one lane: keeps the first nbytes bytes, drops the rest,
// optionally inserts the leading 0x01 pad byte and the trailing 0x80 of the block.
module keccak_pad_word
  import pkg_keccak::*;
(
  input  logic [IN_BUF_SIZE-1:0] word,
  input  logic [3:0]             nbytes,
  input  logic                   first_pad,
  input  logic                   last_slot,
  output logic [IN_BUF_SIZE-1:0] padded
);

  localparam int NB = IN_BUF_SIZE / 8;

  always_comb begin
    padded = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < int'(nbytes)) begin
        padded[8*i +: 8] = word[8*i +: 8];
      end else if (first_pad && (i == int'(nbytes))) begin
        padded[8*i +: 8] = PAD_FIRST;
      end
    end
    // OR rather than assign so a 0x01 already placed in byte 7 becomes 0x81.
    if (last_slot) begin
      padded[IN_BUF_SIZE-1 -: 8] = padded[IN_BUF_SIZE-1 -: 8] | PAD_LAST;
    end
  end

endmodule

// File: rtl/keccak_buffer_in.sv
// Collects message words into rate-sized blocks, applies pad10*1 and hands each
// block to the permutation core over a valid/ready handshake (single-buffered).
module keccak_buffer_in
  import pkg_keccak::*;
(
  input  logic                              clock,
  input  logic                              reset,
  input  logic [IN_BUF_SIZE-1:0]            buffer_input,
  input  logic                              input_valid,
  input  logic                              input_last,
  input  logic [3:0]                        input_bytes,
  output logic                              input_ready,
  output logic [RATE_WORDS*IN_BUF_SIZE-1:0] block_output,
  output logic                              block_valid,
  output logic                              block_last,
  input  logic                              block_ready
);

  buf_in_state_t          state;
  logic [CNT_W-1:0]       word_cnt;
  logic                   pending_pad;
  logic                   pad_started;
  logic [IN_BUF_SIZE-1:0] lanes [RATE_WORDS];

  logic                   at_last_slot;
  logic                   partial_last;
  logic [IN_BUF_SIZE-1:0] pad_word;
  logic [3:0]             pad_nbytes;
  logic                   pad_first;
  logic                   pad_last;
  logic [IN_BUF_SIZE-1:0] lane_value;

  assign at_last_slot = (word_cnt == CNT_W'(RATE_WORDS - 1));
  assign partial_last = input_last && (input_bytes < 4'd8);
  assign input_ready  = (state == FILL);

  // One padder serves both host words (FILL) and synthesized pad lanes (PAD).
  always_comb begin
    if (state == PAD) begin
      pad_word   = '0;
      pad_nbytes = 4'd0;
      pad_first  = !pad_started;
      pad_last   = at_last_slot;
    end else begin
      pad_word   = buffer_input;
      pad_nbytes = partial_last ? input_bytes : 4'd8;
      pad_first  = partial_last;
      pad_last   = partial_last && at_last_slot;
    end
  end

  keccak_pad_word u_pad (
    .word      (pad_word),
    .nbytes    (pad_nbytes),
    .first_pad (pad_first),
    .last_slot (pad_last),
    .padded    (lane_value)
  );

  always_comb begin
    block_output = '0;
    for (int k = 0; k < RATE_WORDS; k++) begin
      block_output[k*IN_BUF_SIZE +: IN_BUF_SIZE] = lanes[k];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= FILL;
      word_cnt    <= '0;
      pending_pad <= 1'b0;
      pad_started <= 1'b0;
      block_valid <= 1'b0;
      block_last  <= 1'b0;
      for (int k = 0; k < RATE_WORDS; k++) begin
        lanes[k] <= '0;
      end
    end else begin
      case (state)
        FILL: begin
          if (input_valid) begin
            lanes[word_cnt] <= lane_value;
            if (!input_last) begin
              if (at_last_slot) begin
                state       <= FULL;
                block_valid <= 1'b1;
                block_last  <= 1'b0;
              end else begin
                word_cnt <= word_cnt + CNT_W'(1);
              end
            end else if (partial_last) begin
              if (at_last_slot) begin
                state       <= FULL;
                block_valid <= 1'b1;
                block_last  <= 1'b1;
              end else begin
                word_cnt    <= word_cnt + CNT_W'(1);
                pad_started <= 1'b1;
                state       <= PAD;
              end
            end else begin
              // A full final word leaves the 0x01 for later; at the last slot
              // that means a whole extra padding block.
              pad_started <= 1'b0;
              if (at_last_slot) begin
                pending_pad <= 1'b1;
                state       <= FULL;
                block_valid <= 1'b1;
                block_last  <= 1'b0;
              end else begin
                word_cnt <= word_cnt + CNT_W'(1);
                state    <= PAD;
              end
            end
          end
        end

        PAD: begin
          lanes[word_cnt] <= lane_value;
          pad_started     <= 1'b1;
          if (at_last_slot) begin
            state       <= FULL;
            block_valid <= 1'b1;
            block_last  <= 1'b1;
          end else begin
            word_cnt <= word_cnt + CNT_W'(1);
          end
        end

        FULL: begin
          if (block_ready) begin
            word_cnt    <= '0;
            block_valid <= 1'b0;
            block_last  <= 1'b0;
            if (pending_pad) begin
              pending_pad <= 1'b0;
              pad_started <= 1'b0;
              state       <= PAD;
            end else begin
              state <= FILL;
            end
          end
        end

        default: state <= FILL;
      endcase
    end
  end

endmodule
